// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
// Holds the AES-128 round count, the inverse key expander FSM state type,
// the RotWord helper and the Rcon lookup. The forward and inverse key
// expanders both import this package.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE_S = 2'd3
    } state_t;

    // Left rotate by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant for rounds 1..10, placed in the most significant byte
    function automatic logic [31:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

endpackage

// File: rtl/inv_key_expand_if.sv
// Control/data bundle of the inverse key expander.
//   start         : one-cycle pulse that begins loading the round-10 key
//   key_in        : round-10 key words, MSW first, four cycles after start
//   round_key_num : stored round key select 0..10
//   r_index       : word select, 0 = [127:96] .. 3 = [31:0]
//   round_key     : selected word (combinational from storage)
//   done / busy   : registered status
// master drives the request side; slave is the expander.
interface inv_key_expand_if;
    logic        start;
    logic [31:0] key_in;
    logic [3:0]  round_key_num;
    logic [1:0]  r_index;
    logic [31:0] round_key;
    logic        done;
    logic        busy;

    modport master (
        output start, key_in, round_key_num, r_index,
        input  round_key, done, busy
    );

    modport slave (
        input  start, key_in, round_key_num, r_index,
        output round_key, done, busy
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197), one byte in, one byte out.
//   a : input byte
//   y : substituted byte
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];
endmodule

// File: rtl/inv_key_expand.sv
// AES-128 inverse key expander.
// Loads the final (round-10) key one word per cycle, then walks the key
// schedule backwards one round per cycle, storing all 11 round keys.
// Any stored word can be read combinationally once done is high.
//   clk, reset : single clock, asynchronous active-high reset
//   bus        : inv_key_expand_if.slave (start/key_in in, round key read
//                port, done/busy status out)
//   dbg_curr_round_key : full 128-bit key at round_key_num (zero when
//                out of range); present only when INV_KEY_DBG_EN is defined
// Timing: start at T0, key words at T1..T4, keys 9..0 at T5..T14,
// done high (busy low) after T15.
module inv_key_expand #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    inv_key_expand_if.slave  bus
`ifdef INV_KEY_DBG_EN
    ,
    output logic [127:0]     dbg_curr_round_key
`endif
);
    import aes_pkg::*;

    state_t       state;
    logic [1:0]   load_cnt;
    logic [3:0]   rnd;
    logic         done_q;
    logic         busy_q;
    logic [127:0] keys [0:NUM_ROUNDS];

    // Backward step: round rnd -> round rnd-1
    logic [127:0] cur;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sub;

    assign cur = keys[rnd];
    assign {w0, w1, w2, w3} = cur;
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = rot_word(p3);

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
    end

    assign p0 = w0 ^ sub ^ rcon(rnd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            load_cnt <= 2'd0;
            rnd      <= 4'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) keys[i] <= '0;
        end else if (bus.start) begin
            // start wins in every state; stored keys are left as they are
            state    <= LOAD;
            load_cnt <= 2'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    case (load_cnt)
                        2'd0: keys[NUM_ROUNDS][127:96] <= bus.key_in;
                        2'd1: keys[NUM_ROUNDS][95:64]  <= bus.key_in;
                        2'd2: keys[NUM_ROUNDS][63:32]  <= bus.key_in;
                        default: keys[NUM_ROUNDS][31:0] <= bus.key_in;
                    endcase
                    load_cnt <= load_cnt + 2'd1;
                    if (load_cnt == 2'd3) begin
                        state <= EXPAND;
                        rnd   <= 4'(NUM_ROUNDS);
                    end
                end
                EXPAND: begin
                    keys[rnd - 4'd1] <= {p0, p1, p2, p3};
                    rnd              <= rnd - 4'd1;
                    if (rnd == 4'd1) state <= DONE_S;
                end
                DONE_S: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: ;
            endcase
        end
    end

    // Read port
    logic [127:0] sel_key;

    always_comb begin
        sel_key = '0;
        if (bus.round_key_num <= 4'(NUM_ROUNDS)) sel_key = keys[bus.round_key_num];
    end

    always_comb begin
        case (bus.r_index)
            2'd0:    bus.round_key = sel_key[127:96];
            2'd1:    bus.round_key = sel_key[95:64];
            2'd2:    bus.round_key = sel_key[63:32];
            default: bus.round_key = sel_key[31:0];
        endcase
    end

    assign bus.done = done_q;
    assign bus.busy = busy_q;

`ifdef INV_KEY_DBG_EN
    assign dbg_curr_round_key = sel_key;
`endif

endmodule

// File: tb/tb_inv_key_expand.sv
// Directed bench for inv_key_expand: FIPS-197 vector, latency, restart,
// mid-operation reset, out-of-range reads, key_in outside LOAD, and a
// round trip against an independent forward key schedule model.
module tb_inv_key_expand;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inv_key_expand_if bus();

`ifdef INV_KEY_DBG_EN
    logic [127:0] dbg;
    inv_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_curr_round_key(dbg)
    );
`else
    inv_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] R0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;

    logic [127:0] exp_rk [0:10];

    // ---------------- forward key schedule model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            logic hi;
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box built from the GF(2^8) inverse and the affine map
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gf_mul(r, x);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    task automatic fwd_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_model(t[31:24]), sbox_model(t[23:16]),
                     sbox_model(t[15:8]), sbox_model(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic read_key(input int num, output logic [127:0] k);
        bus.round_key_num = 4'(num);
        for (int i = 0; i < 4; i++) begin
            bus.r_index = 2'(i);
            #1;
            k[127-32*i -: 32] = bus.round_key;
        end
    endtask

    // Call at posedge+1; returns at T4+1 with status sampled after T0
    task automatic load_key(input logic [127:0] k, output logic b0, output logic d0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        b0 = bus.busy;
        d0 = bus.done;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.key_in = k[127-32*i -: 32];
            @(posedge clk); #1;
        end
        bus.key_in = 32'hdeadbeef;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [127:0] k;
        reset = 1'b1;
        bus.start = 1'b0; bus.key_in = '0; bus.round_key_num = '0; bus.r_index = '0;
        #12;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        read_key(0, k);
        checks++; if (k !== 128'h0) begin errors++; $display("FAIL reset_key0 got %h want 0", k); end
        read_key(10, k);
        checks++; if (k !== 128'h0) begin errors++; $display("FAIL reset_key10 got %h want 0", k); end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips();
        logic b0, d0;
        logic [127:0] k;
        load_key(R10, b0, d0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", b0); end
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL done_after_start got %b want 0", d0); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if ({bus.done, bus.busy} !== 2'b01) begin errors++; $display("FAIL status_T14 got done/busy %b want 01", {bus.done, bus.busy}); end
        @(posedge clk); #1;
        checks++; if ({bus.done, bus.busy} !== 2'b10) begin errors++; $display("FAIL status_T15 got done/busy %b want 10", {bus.done, bus.busy}); end
        read_key(0, k);
        checks++; if (k !== R0) begin errors++; $display("FAIL fips_round0 got %h want %h", k, R0); end
        read_key(1, k);
        checks++; if (k !== R1) begin errors++; $display("FAIL fips_round1 got %h want %h", k, R1); end
        read_key(10, k);
        checks++; if (k !== R10) begin errors++; $display("FAIL fips_round10 got %h want %h", k, R10); end
    endtask

    task automatic test_restart();
        logic b0, d0;
        logic hi = 1'b0;
        logic [127:0] k;
        @(posedge clk); #1;
        load_key(R10, b0, d0);
        repeat (3) begin @(posedge clk); #1; hi = hi | bus.done; end
        load_key(R10, b0, d0);                  // start sampled at T8
        hi = hi | d0;
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", b0); end
        repeat (10) begin @(posedge clk); #1; hi = hi | bus.done; end
        checks++; if (hi !== 1'b0) begin errors++; $display("FAIL restart_early_done got %b want 0", hi); end
        @(posedge clk); #1;                     // T8+15
        checks++; if ({bus.done, bus.busy} !== 2'b10) begin errors++; $display("FAIL restart_T23 got done/busy %b want 10", {bus.done, bus.busy}); end
        read_key(0, k);
        checks++; if (k !== R0) begin errors++; $display("FAIL restart_round0 got %h want %h", k, R0); end
        read_key(1, k);
        checks++; if (k !== R1) begin errors++; $display("FAIL restart_round1 got %h want %h", k, R1); end
    endtask

    task automatic test_reset_mid();
        logic b0, d0;
        bit ok;
        logic [127:0] k;
        @(posedge clk); #1;
        load_key(R10, b0, d0);
        repeat (6) @(posedge clk);              // T10
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL midreset_status got done/busy %b want 00", {bus.done, bus.busy}); end
        for (int r = 0; r <= 10; r++) begin
            read_key(r, k);
            checks++; if (k !== 128'h0) begin errors++; $display("FAIL midreset_key%0d got %h want 0", r, k); end
        end
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got done/busy %b want 00", {bus.done, bus.busy}); end
        load_key(R10, b0, d0);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL post_reset_done got timeout want done"); end
        read_key(0, k);
        checks++; if (k !== R0) begin errors++; $display("FAIL post_reset_round0 got %h want %h", k, R0); end
    endtask

    task automatic test_out_of_range();
        logic bad = 1'b0;
        @(posedge clk); #1;
        for (int n = 11; n < 16; n++) begin
            for (int i = 0; i < 4; i++) begin
                bus.round_key_num = 4'(n);
                bus.r_index = 2'(i);
                #1;
                checks++;
                if (bus.round_key !== 32'h0) begin
                    errors++; $display("FAIL oor_word n=%0d i=%0d got %h want 0", n, i, bus.round_key);
                end
`ifdef INV_KEY_DBG_EN
                checks++;
                if (dbg !== 128'h0) begin errors++; $display("FAIL oor_dbg n=%0d got %h want 0", n, dbg); end
`endif
            end
        end
`ifdef INV_KEY_DBG_EN
        bus.round_key_num = 4'd0;
        #1;
        checks++; if (dbg !== R0) begin errors++; $display("FAIL dbg_round0 got %h want %h", dbg, R0); end
`endif
        bad = 1'b0;
    endtask

    task automatic test_keyin_ignored();
        logic [127:0] k;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            bus.key_in = $urandom;
            @(posedge clk); #1;
        end
        read_key(10, k);
        checks++; if (k !== R10) begin errors++; $display("FAIL keyin_idle_round10 got %h want %h", k, R10); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL keyin_idle_done got %b want 1", bus.done); end
    endtask

    task automatic test_round_trip();
        logic b0, d0;
        bit ok;
        logic [127:0] key, k;
        for (int t = 0; t < 2; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(key);
            @(posedge clk); #1;
            load_key(exp_rk[10], b0, d0);
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rt_done got timeout want done"); end
            for (int r = 0; r <= 10; r++) begin
                read_key(r, k);
                checks++;
                if (k !== exp_rk[r]) begin errors++; $display("FAIL rt_round%0d got %h want %h", r, k, exp_rk[r]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_restart();
        test_reset_mid();
        test_out_of_range();
        test_keyin_ignored();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
